// File: rtl/gbuff_pkg.sv
// Shared types and constants for the global-buffer stream reader.
// Imported by the reader top and its skid FIFO.
package gbuff_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/gbuff_skid_fifo.sv
// Small skid FIFO between the buffer read port and a stream sink.
// Push and pop may coincide; the count then stays unchanged.
module gbuff_skid_fifo
  import gbuff_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      data_o,
  output logic [FIFO_CNT_W-1:0] count_o,
  output logic                  empty_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_q;
  logic [PTR_W-1:0]      rd_q;
  logic [FIFO_CNT_W-1:0] cnt_q;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PTR_W-1:0] inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(FIFO_DEPTH - 1))
      ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = cnt_q == FIFO_CNT_W'(FIFO_DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= inc(wr_q);
      end
      if (do_pop)
        rd_q <= inc(rd_q);
      if (do_push && !do_pop)
        cnt_q <= cnt_q + FIFO_CNT_W'(1);
      else if (do_pop && !do_push)
        cnt_q <= cnt_q - FIFO_CNT_W'(1);
    end
  end

endmodule

// File: rtl/gbuff_stream_reader.sv
// Streams a contiguous (wrapping) region of the global buffer
// onto a valid/ready port, hiding the one-cycle read latency.
module gbuff_stream_reader
  import gbuff_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned LEN_BITS  = ADDR_BITS + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [ADDR_BITS-1:0] base_addr_i,
  input  logic [LEN_BITS-1:0]  len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ADDR_BITS-1:0] rd_index_o,
  input  logic [DATA_BITS-1:0] rd_data_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DATA_BITS-1:0] m_data_o,
  output logic                 m_last_o
);

  localparam int unsigned OCC_W = FIFO_CNT_W + 1;

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_BITS-1:0]  rd_index_q;
  logic [LEN_BITS-1:0]   len_q;
  logic [LEN_BITS-1:0]   issued_q;
  logic                  pend_q;
  logic                  pend_last_q;
  logic [FIFO_CNT_W-1:0] fifo_cnt;
  logic                  fifo_empty;
  logic [DATA_BITS:0]    head;
  logic [OCC_W-1:0]      occ;
  logic                  pop;
  logic                  issue;
  logic                  issue_last;
  logic                  start_go;

  assign m_valid_o  = ~fifo_empty;
  assign m_data_o   = head[DATA_BITS-1:0];
  assign m_last_o   = m_valid_o & head[DATA_BITS];
  assign pop        = m_valid_o & m_ready_i;
  assign busy_o     = state_q != IDLE;
  assign done_o     = state_q == DONE;
  assign rd_index_o = rd_index_q;

  // Words already owed to the FIFO after this cycle's pop.
  assign occ = {1'b0, fifo_cnt}
             + OCC_W'(pend_q)
             - OCC_W'(pop);

  assign issue = (state_q == STREAM)
               && (issued_q < len_q)
               && (occ < OCC_W'(FIFO_DEPTH));
  assign issue_last = issued_q == len_q - LEN_BITS'(1);
  assign start_go   = (state_q == IDLE) && start_i
                    && (len_i != '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i)
          state_d = (len_i == '0) ? DONE : STREAM;
      end
      STREAM: begin
        if (pop && m_last_o)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_index_q  <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      pend_q      <= issue;
      pend_last_q <= issue & issue_last;
      if (start_go) begin
        rd_index_q <= base_addr_i;
        len_q      <= len_i;
        issued_q   <= '0;
      end else if (issue) begin
        rd_index_q <= rd_index_q + ADDR_BITS'(1);
        issued_q   <= issued_q + LEN_BITS'(1);
      end
    end
  end

  gbuff_skid_fifo #(
    .WIDTH (DATA_BITS + 1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (pend_q),
    .data_i  ({pend_last_q, rd_data_i}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_gbuff_stream_reader.sv
// Directed and randomized bench for gbuff_stream_reader against
// a queue-based model of the expected word stream.
module tb_gbuff_stream_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] base_i;
  logic [8:0] len_i;
  logic       busy;
  logic       done;
  logic [7:0] rd_index;
  logic [7:0] rd_data;
  logic       mvalid;
  logic       ready;
  logic [7:0] mdata;
  logic       mlast;

  logic [7:0] mem [256];

  int passed = 0;
  int total  = 0;

  gbuff_stream_reader #(
    .ADDR_BITS (8),
    .DATA_BITS (8),
    .LEN_BITS  (9)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .base_addr_i (base_i),
    .len_i       (len_i),
    .busy_o      (busy),
    .done_o      (done),
    .rd_index_o  (rd_index),
    .rd_data_i   (rd_data),
    .m_valid_o   (mvalid),
    .m_ready_i   (ready),
    .m_data_o    (mdata),
    .m_last_o    (mlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global buffer read port: one-cycle registered read.
  always @(posedge clk) rd_data <= mem[rd_index];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  32'(busy),     0);
    chk({tag, "_done"},  32'(done),     0);
    chk({tag, "_index"}, 32'(rd_index), 0);
    chk({tag, "_valid"}, 32'(mvalid),   0);
    chk({tag, "_data"},  32'(mdata),    0);
    chk({tag, "_last"},  32'(mlast),    0);
  endtask

  // Must be entered just after tick(); that cycle is cycle 0.
  // mode 0: sink always ready; mode 1: random ready plus a
  // 5-cycle stall. hammer keeps start_i high while busy.
  task automatic run_xfer(input logic [7:0] base,
                          input logic [8:0] len,
                          input int mode,
                          input bit hammer,
                          input bit chk_ahead);
    logic [7:0] exp_q [$];
    logic [7:0] idx0;
    logic [7:0] sdata;
    logic       slast;
    bit         stalled;
    bit         any_valid;
    int         got;
    int         dones;
    int         done_cyc;
    int         last_hs;
    int         ahead;
    int         budget;
    for (int k = 0; k < int'(len); k++)
      exp_q.push_back(mem[8'(int'(base) + k)]);
    idx0      = rd_index;
    stalled   = 0;
    any_valid = 0;
    sdata     = '0;
    slast     = 0;
    got       = 0;
    dones     = 0;
    done_cyc  = -1;
    last_hs   = -1;
    budget    = 4 * int'(len) + 40;
    start  = 1'b1;
    base_i = base;
    len_i  = len;
    ready  = (mode == 0);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      tick();
      start = hammer && (done_cyc < 0) && !done;
      if (hammer) begin
        base_i = 8'h00;
        len_i  = 9'd5;
      end
      if (mode == 0)
        ready = 1'b1;
      else if (cyc >= 4 && cyc <= 8)
        ready = 1'b0;
      else
        ready = 1'($urandom_range(0, 1));
      if (cyc == 1 && len != 0) begin
        chk("idx_base", 32'(rd_index), 32'(base));
        chk("busy_stream", 32'(busy), 1);
      end
      if (stalled) begin
        chk("stall_valid", 32'(mvalid), 1);
        chk("stall_data", 32'(mdata), 32'(sdata));
        chk("stall_last", 32'(mlast), 32'(slast));
      end
      if (chk_ahead && busy) begin
        ahead = int'(8'(rd_index - base)) - got;
        chk("read_ahead_le2", 32'(ahead <= 2), 1);
      end
      if (mvalid) begin
        any_valid = 1;
        if (got < int'(len)) begin
          chk("word_data", 32'(mdata), 32'(exp_q[got]));
          chk("word_last", 32'(mlast),
              32'(got == int'(len) - 1));
          if (mode == 0)
            chk("word_cycle", 32'(cyc), 32'(3 + got));
        end else begin
          chk("word_overrun", 32'(got + 1), 32'(len));
        end
        if (ready) begin
          got++;
          if (mlast) last_hs = cyc;
        end
      end
      stalled = mvalid && !ready;
      sdata   = mdata;
      slast   = mlast;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0;
    chk("word_count", 32'(got), 32'(len));
    chk("done_count", 32'(dones), 1);
    chk("idle_after", 32'(busy), 0);
    if (len == 0) begin
      chk("len0_done_cycle", 32'(done_cyc), 1);
      chk("len0_no_valid", 32'(any_valid), 0);
      chk("len0_idx_hold", 32'(rd_index), 32'(idx0));
    end else begin
      chk("done_after_last", 32'(done_cyc), 32'(last_hs + 1));
      if (mode == 0)
        chk("done_cycle", 32'(done_cyc), 32'(3 + int'(len)));
    end
  endtask

  initial begin
    int cnt;
    rst_n  = 1'b0;
    start  = 1'b0;
    base_i = '0;
    len_i  = '0;
    ready  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    #2;
    chk_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    run_xfer(8'h10, 9'd4, 0, 0, 0);
    run_xfer(8'hFE, 9'd4, 0, 0, 0);
    run_xfer(8'($urandom), 9'd8, 1, 0, 1);
    run_xfer(8'h33, 9'd0, 0, 0, 0);
    run_xfer(8'h00, 9'd256, 0, 1, 0);
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3)
      run_xfer(8'($urandom), 9'($urandom_range(1, 20)),
               1, 0, 1);

    start  = 1'b1;
    base_i = 8'h40;
    len_i  = 9'd10;
    ready  = 1'b1;
    cnt    = 0;
    for (int c = 0; c < 20 && cnt < 3; c++) begin
      tick();
      start = 1'b0;
      if (mvalid && ready) cnt++;
    end
    chk("rst_mid_words", 32'(cnt), 3);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    repeat (2) begin
      tick();
      chk("rst_hold_done", 32'(done), 0);
      chk("rst_hold_valid", 32'(mvalid), 0);
    end
    rst_n = 1'b1;
    tick();
    run_xfer(8'h80, 9'd5, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
